// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, PC-select encodings, handler
// address, processor ID and the EXL state type.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [2:0] PCSEL_PC4    = 3'b000;
    localparam logic [2:0] PCSEL_BRANCH = 3'b001;
    localparam logic [2:0] PCSEL_JUMP   = 3'b010;
    localparam logic [2:0] PCSEL_REG    = 3'b011;
    localparam logic [2:0] PCSEL_EPC    = 3'b100;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE   = 32'h5043_0004;

    typedef enum logic {
        EXL_NORMAL  = 1'b0,
        EXL_HANDLER = 1'b1
    } exl_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId registers, interrupt and
// exception entry, eret handling and mfc0 read path.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut,
    output logic [2:0]  PcSel,
    output logic [31:0] HandlerPc
);

    exl_state_e  state_q, state_d;
    logic [5:0]  im_q;
    logic        ie_q;
    logic        cause_bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q;

    logic        exl;
    logic        int_term;
    logic        wr_en;
    logic        wr_sr;
    logic        wr_epc;

    assign exl      = (state_q == EXL_HANDLER);
    assign int_term = ie_q && (|(HWInt & im_q));
    // Reset masks the request so nothing is flushed while the core restarts.
    assign IntReq   = !reset && !exl && (int_term || (ExcCode_in != 5'd0));
    // An mtc0 is lost when the same instruction is being trapped.
    assign wr_en    = We && !IntReq;
    assign wr_sr    = wr_en && (A2 == CP0_SR);
    assign wr_epc   = wr_en && (A2 == CP0_EPC);

    assign PcSel     = (!reset && EXLClr) ? PCSEL_EPC : PCSEL_PC4;
    assign EPC       = epc_q;
    assign HandlerPc = HANDLER_ADDR;

    // EXL state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= EXL_NORMAL;
        else       state_q <= state_d;
    end

    // EXL next state: trap entry, eret, or software rewriting SR.EXL (eret wins).
    always_comb begin
        state_d = state_q;
        case (state_q)
            EXL_NORMAL: begin
                if (IntReq)                            state_d = EXL_HANDLER;
                else if (wr_sr && DIn[1] && !EXLClr)   state_d = EXL_HANDLER;
            end
            EXL_HANDLER: begin
                if (EXLClr)                            state_d = EXL_NORMAL;
                else if (wr_sr && !DIn[1])             state_d = EXL_NORMAL;
            end
            default: state_d = EXL_NORMAL;
        endcase
    end

    // SR/Cause/EPC update: trap entry captures context, otherwise mtc0 applies.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            ie_q       <= 1'b0;
            cause_bd_q <= 1'b0;
            ip_q       <= 6'd0;
            exc_q      <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            ip_q <= HWInt;
            if (IntReq) begin
                epc_q      <= BD ? (word_align(PC) - 32'd4) : word_align(PC);
                cause_bd_q <= BD;
                exc_q      <= int_term ? 5'd0 : ExcCode_in;
            end else begin
                if (wr_sr) begin
                    im_q <= DIn[15:10];
                    ie_q <= DIn[0];
                end
                if (wr_epc) epc_q <= word_align(DIn);
            end
        end
    end

    // mfc0 read mux over the pre-edge register values.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            CP0_SR:    DOut = {16'd0, im_q, 8'd0, exl, ie_q};
            CP0_CAUSE: DOut = {cause_bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
            CP0_EPC:   DOut = epc_q;
            CP0_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;
    logic [2:0]  PcSel;
    logic [31:0] HandlerPc;

    int n_cmp = 0;
    int n_err = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
        .PC(PC), .BD(BD), .ExcCode_in(ExcCode_in), .HWInt(HWInt),
        .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut),
        .PcSel(PcSel), .HandlerPc(HandlerPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; We = 1'b0;
        PC = 32'd0; BD = 1'b0; ExcCode_in = 5'd5; HWInt = 6'h3f; EXLClr = 1'b1;
        tick; tick;
        #1 chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        chk("rst_pcsel", {29'd0, PcSel}, 32'd0);
        A1 = 5'd12; #1 chk("rst_sr", DOut, 32'd0);
        A1 = 5'd13; #1 chk("rst_cause", DOut, 32'd0);
        A1 = 5'd14; #1 chk("rst_epc", DOut, 32'd0);
        chk("handler_pc", HandlerPc, 32'h0000_4180);

        ExcCode_in = 5'd0; HWInt = 6'd0; EXLClr = 1'b0; reset = 1'b0;
        tick;
        A1 = 5'd15; #1 chk("prid", DOut, 32'h5043_0004);
        A1 = 5'd3;  #1 chk("unmapped", DOut, 32'd0);

        // interrupt entry
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick;
        We = 1'b0; A1 = 5'd12;
        #1 chk("sr_write", DOut, 32'h0000_0401);
        chk("idle_intreq", {31'd0, IntReq}, 32'd0);
        HWInt = 6'b000001; PC = 32'h3008; BD = 1'b0;
        #1 chk("irq_intreq", {31'd0, IntReq}, 32'd1);
        tick;
        #1 chk("irq_held_off", {31'd0, IntReq}, 32'd0);
        chk("irq_epc", EPC, 32'h3008);
        A1 = 5'd12; #1 chk("irq_sr", DOut, 32'h0000_0403);
        A1 = 5'd13; #1 chk("irq_cause", DOut, 32'h0000_0400);

        // eret
        HWInt = 6'd0; EXLClr = 1'b1;
        #1 chk("eret_pcsel", {29'd0, PcSel}, 32'd4);
        chk("eret_epc", EPC, 32'h3008);
        tick;
        EXLClr = 1'b0;
        #1 chk("post_eret_pcsel", {29'd0, PcSel}, 32'd0);
        A1 = 5'd12; #1 chk("post_eret_sr", DOut, 32'h0000_0401);
        chk("post_eret_epc", EPC, 32'h3008);

        // synchronous exception in a delay slot
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0400;
        tick;
        We = 1'b0; ExcCode_in = 5'd10; PC = 32'h3010; BD = 1'b1;
        #1 chk("exc_intreq", {31'd0, IntReq}, 32'd1);
        tick;
        ExcCode_in = 5'd0; BD = 1'b0;
        #1 chk("exc_epc", EPC, 32'h300C);
        A1 = 5'd13; #1 chk("exc_cause", DOut, 32'h8000_0028);
        A1 = 5'd12; #1 chk("exc_sr", DOut, 32'h0000_0402);

        // no nesting while in the handler
        HWInt = 6'h3f; ExcCode_in = 5'd3; PC = 32'h3040;
        #1 chk("nest_intreq", {31'd0, IntReq}, 32'd0);
        tick;
        #1 chk("nest_epc", EPC, 32'h300C);
        A1 = 5'd13; #1 chk("nest_cause", DOut, 32'h8000_FC28);

        // reset out of the handler
        reset = 1'b1;
        tick;
        #1 chk("hrst_intreq", {31'd0, IntReq}, 32'd0);
        A1 = 5'd12; #1 chk("hrst_sr", DOut, 32'd0);
        HWInt = 6'd0; ExcCode_in = 5'd0; reset = 1'b0;
        tick;

        // mtc0 EPC collides with a trap
        ExcCode_in = 5'd4; PC = 32'h3020; BD = 1'b0;
        We = 1'b1; A2 = 5'd14; DIn = 32'hFFFF_FFFF;
        #1 chk("clash_intreq", {31'd0, IntReq}, 32'd1);
        tick;
        We = 1'b0; ExcCode_in = 5'd0;
        #1 chk("clash_epc", EPC, 32'h3020);
        A1 = 5'd13; #1 chk("clash_cause", DOut, 32'h0000_0010);

        // software clears EXL through SR
        We = 1'b1; A2 = 5'd12; DIn = 32'd0;
        tick;
        We = 1'b0; A1 = 5'd12;
        #1 chk("swclr_sr", DOut, 32'd0);
        ExcCode_in = 5'd8;
        #1 chk("swclr_intreq", {31'd0, IntReq}, 32'd1);
        ExcCode_in = 5'd0;

        // Cause is not writable; EPC writes drop the low bits
        We = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick;
        A2 = 5'd14; DIn = 32'h1234_5677;
        tick;
        We = 1'b0; A1 = 5'd13;
        #1 chk("cause_ro", DOut, 32'h0000_0010);
        chk("epc_align", EPC, 32'h1234_5674);

        // interrupt beats a simultaneous exception code
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0C01;
        tick;
        We = 1'b0; HWInt = 6'b000010; ExcCode_in = 5'd5; PC = 32'h3057; BD = 1'b0;
        #1 chk("prio_intreq", {31'd0, IntReq}, 32'd1);
        tick;
        HWInt = 6'd0; ExcCode_in = 5'd0;
        A1 = 5'd13; #1 chk("prio_cause", DOut, 32'h0000_0800);
        chk("prio_epc", EPC, 32'h3054);

        // eret wins over mtc0 setting SR.EXL
        EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0402;
        tick;
        EXLClr = 1'b0; We = 1'b0; A1 = 5'd12;
        #1 chk("eret_vs_mtc0", DOut, 32'h0000_0400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
